// File: rtl/chip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chip_pkg
//  Purpose  : Shared state encodings and constants for the burst buffer.
//  Revision : 1.0  initial release
// ============================================================================
package chip_pkg;

  // Controller states of the capture-and-forward buffer
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUF  = 2'd1,
    S_PUSH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // cfg_mode encodings
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  // Frame length used by chip_top when software has not programmed one
  localparam int LEN_CHIP = 4000;

endpackage
`default_nettype wire

// File: rtl/chip_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : chip_fifo_sync
//  Purpose  : Single-clock FIFO, 2^AW words deep, registered read data.
//  Revision : 1.0  initial release
// ============================================================================
module chip_fifo_sync #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wrreq,
  input  logic [DW-1:0] data,
  input  logic          rdreq,
  output logic [DW-1:0] q,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   usedw
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign usedw = wr_ptr - rd_ptr;
  assign empty = (usedw == '0);
  assign full  = usedw[AW];

  // Storage array: no reset, only written words are ever read
  always_ff @(posedge clk_sys) begin
    if (wrreq && !full) mem[wr_ptr[AW-1:0]] <= data;
  end

  // Pointer update and registered read port
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q      <= '0;
    end else begin
      if (wrreq && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rdreq && !empty) begin
        q      <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/chip_burst_buf.sv
`default_nettype none
// ============================================================================
//  Module   : chip_burst_buf
//  Purpose  : Captures a frame of cfg_len samples into a FIFO, then forwards
//             it word by word to the UART transmitter under vld/done.
//  Revision : 1.0  initial release
// ============================================================================
module chip_burst_buf #(
  parameter int DW    = 16,
  parameter int AW    = 12,
  parameter int LEN_W = 20,
  parameter int OVF_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_mode,
  input  logic             arm,
  input  logic [DW-1:0]    d_data,
  input  logic             d_vld,
  output logic [DW-1:0]    tx_data,
  output logic             tx_vld,
  input  logic             tx_done,
  output logic             busy,
  output logic             frame_done,
  output logic [OVF_W-1:0] ovf_cnt
);

  import chip_pkg::*;

  localparam int               DEPTH   = 1 << AW;
  localparam logic [LEN_W:0]   DEPTH_X = (LEN_W+1)'(DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic             armed;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W-1:0] cnt_buf;
  logic [LEN_W-1:0] cnt_push;
  logic             fetch;
  logic             load;
  logic             start;
  logic             accept;
  logic             last_buf;
  logic             last_push;
  logic             enter_push;
  logic             drop;
  logic             wrreq;
  logic             rdreq;
  logic [DW-1:0]    rd_q;
  logic             fifo_empty;
  logic             fifo_full;
  logic [AW:0]      fifo_usedw;

  // Frame length is clamped to the FIFO depth so the FIFO cannot overflow
  assign len_clamp = ({1'b0, cfg_len} > DEPTH_X) ? DEPTH_X[LEN_W-1:0] : cfg_len;

  // A frame only starts on an empty FIFO, so no stale words can leak out
  assign start = (state == S_IDLE) && d_vld && (cfg_len != '0) &&
                 ((cfg_mode == MODE_CONT) || armed) && (fifo_usedw == '0);

  assign accept     = (state == S_PUSH) && tx_vld && tx_done;
  assign last_buf   = ((cnt_buf + LEN_W'(1)) == len_q);
  assign last_push  = ((cnt_push + LEN_W'(1)) == len_q);
  assign drop       = d_vld && ((state == S_PUSH) || (state == S_DONE));
  assign wrreq      = (start || ((state == S_BUF) && d_vld)) && !fifo_full;
  assign rdreq      = fetch && !fifo_empty;
  assign enter_push = (state != S_PUSH) && (state_nxt == S_PUSH);

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  chip_fifo_sync #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .wrreq   (wrreq),
    .data    (d_data),
    .rdreq   (rdreq),
    .q       (rd_q),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .usedw   (fifo_usedw)
  );

  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len_clamp == LEN_W'(1)) ? S_PUSH : S_BUF;
      S_BUF:  if (d_vld && last_buf) state_nxt = S_PUSH;
      S_PUSH: if (accept && last_push) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame control: latched length, arm flag and per-frame counters
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      armed    <= 1'b0;
      cnt_buf  <= '0;
      cnt_push <= '0;
    end else begin
      if (start) len_q <= len_clamp;
      // An arm arriving in S_DONE is swallowed by the clear
      if (state == S_DONE) armed <= 1'b0;
      else if (arm)        armed <= 1'b1;
      if (state == S_DONE) begin
        cnt_buf  <= '0;
        cnt_push <= '0;
      end else begin
        if (start)                           cnt_buf <= LEN_W'(1);
        else if ((state == S_BUF) && d_vld)  cnt_buf <= cnt_buf + LEN_W'(1);
        if (accept) cnt_push <= cnt_push + LEN_W'(1);
      end
    end
  end

  // Push pipeline: fetch -> FIFO read -> load tx word, held until tx_done
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fetch   <= 1'b0;
      load    <= 1'b0;
      tx_data <= '0;
      tx_vld  <= 1'b0;
    end else begin
      fetch <= enter_push || (accept && !last_push);
      load  <= rdreq;
      if (load) begin
        tx_data <= rd_q;
        tx_vld  <= 1'b1;
      end else if (accept) begin
        tx_vld  <= 1'b0;
      end
    end
  end

  // Saturating count of samples that arrive while the frame is draining
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                             ovf_cnt <= '0;
    else if (drop && (ovf_cnt != '1))       ovf_cnt <= ovf_cnt + OVF_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_chip_burst_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chip_burst_buf
//  Purpose  : Directed self-checking bench for chip_burst_buf (AW=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_chip_burst_buf;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int LEN_W = 20;
  localparam int OVF_W = 16;

  logic             clk_sys = 1'b0;
  logic             rst_n   = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_mode = 1'b0;
  logic             arm     = 1'b0;
  logic [DW-1:0]    d_data  = '0;
  logic             d_vld   = 1'b0;
  logic [DW-1:0]    tx_data;
  logic             tx_vld;
  logic             tx_done = 1'b0;
  logic             busy;
  logic             frame_done;
  logic [OVF_W-1:0] ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Results gathered by serve()
  logic [DW-1:0] got [0:15];
  int got_n, fd_cnt, unstable, vld_stuck;

  chip_burst_buf #(
    .DW    (DW),
    .AW    (AW),
    .LEN_W (LEN_W),
    .OVF_W (OVF_W)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .arm        (arm),
    .d_data     (d_data),
    .d_vld      (d_vld),
    .tx_data    (tx_data),
    .tx_vld     (tx_vld),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; d_vld = 1'b0; tx_done = 1'b0; d_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic drive_samples(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      d_vld  = 1'b1;
      d_data = first + DW'(i);
      tick();
    end
    d_vld = 1'b0;
  endtask

  // UART model: acknowledges each word dly cycles after its tx_vld rise,
  // records words until frame_done is seen or the budget runs out.
  task automatic serve(input int dly, input int budget);
    int cyc = 0;
    int k = 0;
    bit in_word = 0;
    bit ack_sent = 0;
    bit done = 0;
    logic [DW-1:0] hold = '0;
    got_n = 0; fd_cnt = 0; unstable = 0; vld_stuck = 0;
    while (!done && cyc < budget) begin
      tx_done = 1'b0;
      if (ack_sent) begin
        ack_sent = 0;
        in_word  = 0;
        if (tx_vld) vld_stuck++;
      end
      if (frame_done) begin
        fd_cnt++;
        done = 1;
      end else if (tx_vld) begin
        if (!in_word) begin
          in_word = 1; hold = tx_data; k = 0;
          if (got_n < 16) got[got_n] = tx_data;
          got_n++;
        end else if (tx_data !== hold) begin
          unstable++;
        end
        k++;
        if (k >= dly) begin
          tx_done = 1'b1;
          ack_sent = 1;
        end
      end
      if (!done) begin
        tick();
        cyc++;
      end
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL reset_tx_vld: got %b want 0", tx_vld); end
    n_checks++; if (tx_data !== 16'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0000", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_oneshot_basic();
    do_reset();
    cfg_mode = 1'b0; cfg_len = 20'd4;
    // Unarmed one-shot: sample must be ignored
    drive_samples(16'h00AA, 1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL unarmed_start: busy %b want 0", busy); end
    pulse_arm();
    drive_samples(16'h0011, 4);
    serve(3, 200);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL basic_count: got %0d words want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== 16'h0011 + 16'(i)) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, got[i], 16'h0011 + 16'(i)); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d want 1", fd_cnt); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL basic_stable: %0d changes want 0", unstable); end
    n_checks++; if (vld_stuck !== 0) begin n_fail++; $display("FAIL basic_vld_drop: %0d late drops want 0", vld_stuck); end
    tick();
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_fd_pulse: got %b want 0", frame_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    n_checks++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_ovf: got %0d want 0", ovf_cnt); end
    // armed cleared by S_DONE: a new sample must not start a frame
    drive_samples(16'h00BB, 2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_rearm: busy %b want 0", busy); end
  endtask

  task automatic test_slow_drops();
    do_reset();
    cfg_mode = 1'b0; cfg_len = 20'd3;
    pulse_arm();
    d_vld = 1'b1;
    d_data = 16'h0021; tick();
    d_data = 16'h0022; tick();
    d_data = 16'h0023; tick();
    d_data = 16'hEEEE;
    serve(20, 300);
    tick();              // S_DONE edge still sees d_vld
    d_vld = 1'b0;
    tick();
    n_checks++; if (got_n !== 3) begin n_fail++; $display("FAIL slow_count: got %0d words want 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 16'h0021 + 16'(i)) begin n_fail++; $display("FAIL slow_word%0d: got %h want %h", i, got[i], 16'h0021 + 16'(i)); end
    end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL slow_stable: %0d changes want 0", unstable); end
    // 3 words x (20 wait + 2 latency) cycles in S_PUSH, plus one S_DONE cycle
    n_checks++; if (ovf_cnt !== 16'd67) begin n_fail++; $display("FAIL slow_ovf: got %0d want 67", ovf_cnt); end
  endtask

  task automatic test_continuous();
    do_reset();
    cfg_mode = 1'b1; cfg_len = 20'd2;
    for (int f = 0; f < 3; f++) begin
      drive_samples(16'h000A + 16'(2*f), 2);
      serve(1, 50);
      tick();
      n_checks++; if (got_n !== 2) begin n_fail++; $display("FAIL cont_count%0d: got %0d want 2", f, got_n); end
      n_checks++; if (got[0] !== 16'h000A + 16'(2*f)) begin n_fail++; $display("FAIL cont_w0_f%0d: got %h want %h", f, got[0], 16'h000A + 16'(2*f)); end
      n_checks++; if (got[1] !== 16'h000B + 16'(2*f)) begin n_fail++; $display("FAIL cont_w1_f%0d: got %h want %h", f, got[1], 16'h000B + 16'(2*f)); end
      n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL cont_fd%0d: got %0d want 1", f, fd_cnt); end
    end
    n_checks++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL cont_ovf: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_len_edges();
    // cfg_len = 0: never leaves idle
    do_reset();
    cfg_mode = 1'b1; cfg_len = 20'd0;
    drive_samples(16'h0070, 4);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", busy); end
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL len0_vld: got %b want 0", tx_vld); end
    n_checks++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL len0_ovf: got %0d want 0", ovf_cnt); end
    // cfg_len = 1: straight to push, word visible 2 cycles after entry
    cfg_mode = 1'b0; cfg_len = 20'd1;
    pulse_arm();
    drive_samples(16'h0055, 1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL len1_busy: got %b want 1", busy); end
    tick();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL len1_early_vld: got %b want 0", tx_vld); end
    tick();
    n_checks++; if (tx_vld !== 1'b1) begin n_fail++; $display("FAIL len1_vld_rise: got %b want 1", tx_vld); end
    serve(1, 50);
    tick();
    n_checks++; if (got_n !== 1) begin n_fail++; $display("FAIL len1_count: got %0d want 1", got_n); end
    n_checks++; if (got[0] !== 16'h0055) begin n_fail++; $display("FAIL len1_word: got %h want 0055", got[0]); end
    // cfg_len = 13 with 8-deep FIFO: clamp to 8, remaining 5 dropped
    do_reset();
    cfg_mode = 1'b0; cfg_len = 20'd13;
    pulse_arm();
    drive_samples(16'h0031, 13);
    serve(1, 200);
    tick();
    n_checks++; if (got_n !== 8) begin n_fail++; $display("FAIL clamp_count: got %0d want 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== 16'h0031 + 16'(i)) begin n_fail++; $display("FAIL clamp_word%0d: got %h want %h", i, got[i], 16'h0031 + 16'(i)); end
    end
    n_checks++; if (ovf_cnt !== 16'd5) begin n_fail++; $display("FAIL clamp_ovf: got %0d want 5", ovf_cnt); end
  endtask

  task automatic test_reset_mid_push();
    int w;
    do_reset();
    cfg_mode = 1'b0; cfg_len = 20'd4;
    pulse_arm();
    drive_samples(16'h0041, 4);
    w = 0; while (!tx_vld && w < 10) begin tick(); w++; end
    n_checks++; if (tx_data !== 16'h0041 || tx_vld !== 1'b1) begin n_fail++; $display("FAIL rst_word1: got %h vld %b want 0041 vld 1", tx_data, tx_vld); end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    w = 0; while (!tx_vld && w < 10) begin tick(); w++; end
    n_checks++; if (tx_data !== 16'h0042 || tx_vld !== 1'b1) begin n_fail++; $display("FAIL rst_word2: got %h vld %b want 0042 vld 1", tx_data, tx_vld); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL rst_async_vld: got %b want 0", tx_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_arm();
    drive_samples(16'h0051, 4);
    serve(2, 100);
    tick();
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL rst_new_count: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== 16'h0051 + 16'(i)) begin n_fail++; $display("FAIL rst_new_word%0d: got %h want %h", i, got[i], 16'h0051 + 16'(i)); end
    end
  endtask

  task automatic test_spurious_done();
    do_reset();
    cfg_mode = 1'b0; cfg_len = 20'd3;
    pulse_arm();
    drive_samples(16'h0061, 3);
    // tx_done pulses during the two cycles before the first word appears
    tx_done = 1'b1; tick();
    n_checks++; if (tx_vld !== 1'b0) begin n_fail++; $display("FAIL spur_pre_vld: got %b want 0", tx_vld); end
    tick();
    tx_done = 1'b0;
    serve(2, 100);
    tick();
    n_checks++; if (got_n !== 3) begin n_fail++; $display("FAIL spur_count: got %0d want 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 16'h0061 + 16'(i)) begin n_fail++; $display("FAIL spur_word%0d: got %h want %h", i, got[i], 16'h0061 + 16'(i)); end
    end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL spur_fd: got %0d want 1", fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_oneshot_basic();
    test_slow_drops();
    test_continuous();
    test_len_edges();
    test_reset_mid_push();
    test_spurious_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
